// File: rtl/point_mult_job_controller.sv
// Job sequencer in front of one point_mul_double_and_add instance.
// Handles the k == 0 bypass, watchdog abort and a completed-result counter.
module point_mult_job_controller #(
  parameter int P_WIDTH        = 377,
  parameter int TAG_W          = 8,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] in_Px,
  input  logic [P_WIDTH-1:0] in_Py,
  input  logic [P_WIDTH-1:0] in_k,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               mul_Reset,
  output logic [P_WIDTH-1:0] mul_Px,
  output logic [P_WIDTH-1:0] mul_Py,
  output logic [P_WIDTH-1:0] mul_k,
  input  logic [P_WIDTH-1:0] mul_Rx,
  input  logic [P_WIDTH-1:0] mul_Ry,
  input  logic               mul_Done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_Rx,
  output logic [P_WIDTH-1:0] out_Ry,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_inf,
  output logic               out_timeout,
  output logic               busy,
  output logic [CNT_W-1:0]   jobs_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [P_WIDTH-1:0] px_q, px_d;
  logic [P_WIDTH-1:0] py_q, py_d;
  logic [P_WIDTH-1:0] k_q, k_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [P_WIDTH-1:0] rx_q, rx_d;
  logic [P_WIDTH-1:0] ry_q, ry_d;
  logic               inf_q, inf_d;
  logic               to_q, to_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    k_d     = k_q;
    tag_d   = tag_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    inf_d   = inf_q;
    to_d    = to_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (in_valid) begin
          px_d  = in_Px;
          py_d  = in_Py;
          k_d   = in_k;
          tag_d = in_tag;
          if (in_k == '0) begin
            rx_d    = '0;
            ry_d    = '0;
            inf_d   = 1'b1;
            to_d    = 1'b0;
            state_d = S_OUT;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      (state_q == S_LOAD): begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      (state_q == S_RUN): begin
        wd_d = wd_q + 1'b1;
        // wd_q == 0 marks the first RUN cycle, where Done may be stale
        if (wd_q != '0 && mul_Done) begin
          rx_d    = mul_Rx;
          ry_d    = mul_Ry;
          inf_d   = 1'b0;
          to_d    = 1'b0;
          state_d = S_OUT;
        end else if (wd_q == WD_LAST) begin
          rx_d    = '0;
          ry_d    = '0;
          inf_d   = 1'b0;
          to_d    = 1'b1;
          state_d = S_OUT;
        end
      end
      (state_q == S_OUT): begin
        if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      px_q    <= '0;
      py_q    <= '0;
      k_q     <= '0;
      tag_q   <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      inf_q   <= 1'b0;
      to_q    <= 1'b0;
      wd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      k_q     <= k_d;
      tag_q   <= tag_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      inf_q   <= inf_d;
      to_q    <= to_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_OUT);
  assign mul_Reset   = (state_q != S_RUN);
  assign mul_Px      = px_q;
  assign mul_Py      = py_q;
  assign mul_k       = k_q;
  assign out_Rx      = rx_q;
  assign out_Ry      = ry_q;
  assign out_tag     = tag_q;
  assign out_inf     = inf_q;
  assign out_timeout = to_q;
  assign jobs_done   = cnt_q;

endmodule

// File: doc/point_mult_job_controller.md
Name: point_mult_job_controller

Overview:
- Initiator-side sequencer for point_mul_double_and_add.
- Accepts (point, scalar, tag) jobs on a valid/ready input stream and drives the multiplier's P/k/Reset inputs.
- Waits for the multiplier's Done, captures R, and returns (R, tag, status) on a valid/ready output stream.
- Sits between the MSM bucket scheduler and a single multiplier instance. Handles the k == 0 bypass, a watchdog timeout and a completion counter.

Parameters:
- P_WIDTH, 377, field element width; also the scalar width.
- TAG_W, 8, job tag width, passed through unchanged.
- TIMEOUT_CYCLES, 2**20, maximum RUN cycles before the job is aborted; must be ≥ 2.
- CNT_W, 32, width of the completed-job counter.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  controller can accept a job.
- in_Px  in  P_WIDTH  affine x of input point.
- in_Py  in  P_WIDTH  affine y of input point.
- in_k  in  P_WIDTH  scalar.
- in_tag  in  TAG_W  job tag.
- mul_Reset  out  1  drives the multiplier's Reset.
- mul_Px  out  P_WIDTH  to multiplier P.x.
- mul_Py  out  P_WIDTH  to multiplier P.y.
- mul_k  out  P_WIDTH  to multiplier k.
- mul_Rx  in  P_WIDTH  from multiplier R.x.
- mul_Ry  in  P_WIDTH  from multiplier R.y.
- mul_Done  in  1  multiplier Done (level).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_Rx  out  P_WIDTH  result x.
- out_Ry  out  P_WIDTH  result y.
- out_tag  out  TAG_W  tag of the job.
- out_inf  out  1  result is the point at infinity (k == 0).
- out_timeout  out  1  job aborted by watchdog; Rx/Ry are 0.
- busy  out  1  state != IDLE.
- jobs_done  out  CNT_W  count of results accepted downstream.

Behaviour:
- Reset (synchronous, dominates everything, including mid-job):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, mul_Reset = 1, busy = 0.
  - All data outputs = 0, jobs_done = 0, watchdog = 0.
  - An in-flight job is discarded; no output is produced for it.
- States: IDLE, LOAD, RUN, OUT.
- IDLE:
  - in_ready = 1; mul_Reset held 1, so the multiplier stays parked.
  - On in_valid & in_ready, latch Px, Py, k and tag into the job registers.
  - If the latched k == 0: go straight to OUT with Rx = Ry = 0, out_inf = 1. The multiplier is never released.
  - Otherwise go to LOAD.
- LOAD (exactly 1 cycle):
  - mul_Px/mul_Py/mul_k present the job registers; mul_Reset = 1.
  - Next state RUN; watchdog cleared.
- RUN:
  - mul_Reset = 0; mul_P*/mul_k held stable for the whole state.
  - Watchdog increments each cycle.
  - mul_Done is ignored in the first RUN cycle, which guards against a stale Done from the previous job. It is sampled from the second RUN cycle on.
  - On sampled mul_Done = 1: capture mul_Rx/mul_Ry into out_Rx/out_Ry, set out_inf = 0, out_timeout = 0, go to OUT.
  - If the watchdog reaches TIMEOUT_CYCLES without Done: Rx = Ry = 0, out_timeout = 1, go to OUT.
  - Done and timeout in the same cycle: Done wins.
- OUT:
  - out_valid = 1; mul_Reset = 1 (multiplier re-parked).
  - Outputs are registered and stable until accepted.
  - On out_ready: go to IDLE, jobs_done += 1. This includes inf and timeout results; jobs_done wraps modulo 2^CNT_W.
  - No new job is accepted in the same cycle; there is no input/output overlap.
- in_ready = 1 only in IDLE. Input data is ignored when in_ready = 0.
- Latency, from the handshake at cycle t with a multiplier taking L RUN cycles to assert Done:
  - Cycle t+1: LOAD.
  - Cycles t+2 .. t+1+L: RUN.
  - Cycle t+2+L: out_valid = 1.
  - k == 0 job: out_valid = 1 at t+1.
- mul_Px/mul_Py/mul_k always reflect the job registers, zeroed only by Reset.
- Only one job is outstanding at a time; the tag is returned unchanged.

Test Plan:
- Real multiplier, P = params.base_point, k = 1, tag 0x5A → one result, Rx/Ry = base_point.x/y, out_tag 0x5A, inf = 0, timeout = 0, jobs_done = 1.
- Mock multiplier with L = 7, k = 3 → out_valid asserts exactly 9 cycles after the input handshake. mul_Reset is 1 in LOAD and 0 for exactly the RUN cycles, and mul inputs are stable throughout.
- k = 0, tag 0x11 → out_valid on the next cycle, inf = 1, Rx = Ry = 0. mul_Reset never deasserts.
- Mock multiplier that never asserts Done, TIMEOUT_CYCLES = 16 → out_timeout = 1 after 16 RUN cycles, Rx = Ry = 0. The next job completes normally.
- Mock holds Done = 1 continuously from the previous job → Done is ignored in the first RUN cycle; the result is captured from the second RUN cycle.
- out_ready held 0 for 20 cycles → outputs are stable and in_ready = 0 throughout. Asserting Reset in RUN mid-job → next cycle IDLE, out_valid = 0, jobs_done = 0.
